toggle_shift_pipe: RTL
======================

Name: toggle_shift_pipe

Overview:
- Parametrised, multi-channel generalisation of the toggle/shift flop pair in the clocking testcases.
- Per channel: stage 0 is a toggle/load register feeding a DEPTH-stage shift chain.
- A registered OR of stage 0 and stage 1 provides the fixed-latency, synthesizable replacement for the continuous `#2` delayed OR.
- A saturating fill counter reports when the chain holds only post-load data. It sits in the clock-generation/checker area as a reusable stimulus and phase source.

Parameters:
- WIDTH, 4, number of independent channels (≥1).
- DEPTH, 3, shift stages per channel including stage 0 (≥2).
- RST_VAL, '0, WIDTH-bit reset value of stage 0.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance: stage 0 toggles, chain shifts.
- load  in  1  synchronous load of stage 0; clears fill count.
- load_val  in  WIDTH  value loaded into stage 0.
- q0  out  WIDTH  stage 0 contents.
- tap  out  WIDTH  stage DEPTH-1 contents.
- or_out  out  WIDTH  registered q0 | stage 1.
- full  out  1  chain contains only data produced since last load/reset.

Behaviour:
- Reset (rst_n low, async assert, sync-released use):
  - stage 0 = RST_VAL; stages 1..DEPTH-1 = 0.
  - or_out = 0; fill = 0; full = 0.
- Reset mid-operation overrides everything immediately. No state survives.
- Stage 0 next value, by priority:
  - load=1: load_val.
  - else en=1: ~stage0.
  - else: hold.
- Stages k=1..DEPTH-1:
  - en=1: stage k ← stage k-1 (old values), regardless of load.
  - en=0: hold.
- load and en in the same cycle:
  - stage 0 takes load_val.
  - stage 1 takes old stage 0.
  - fill cleared to 0.
- Fill counter, width $clog2(DEPTH):
  - load=1: 0.
  - else en=1 and fill<DEPTH-1: fill+1.
  - Saturates at DEPTH-1; never wraps.
- full is combinational from fill: full = (fill == DEPTH-1).
- or_out is updated every clock, independent of en: or_out ← stage0 | stage1. Latency is 1 cycle after a stage change.
- q0 and tap are direct register outputs; no extra latency.
- Channels are bitwise independent. There is no cross-channel arithmetic.
- The x-free guarantee applies only while stimulus is known. load_val containing X propagates as X; the block does not mask it.

Optional Feature:
- Macro: TOGGLE_SHIFT_PIPE_CHG_DET_EN.
- When defined:
  - Adds output chg [WIDTH], registered.
  - chg[i] ← (stage0_next[i] != stage0[i]), so it pulses 1 cycle, aligned with the new q0 value.
  - Reset value 0.
  - A load of an equal value yields no pulse.
  - This is the clocked equivalent of a follow-on-change flop.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package toggle_shift_pkg holds:
  - localparam function fill_w(depth) = $clog2(depth).
  - typedef enum {TSP_HOLD, TSP_TOGGLE, TSP_LOAD} tsp_op_e, used for stage 0 select and in bench coverage.
- One natural sub-module, toggle_shift_lane (single-bit channel: stage 0 plus chain plus OR register), generated WIDTH times.
- The fill counter and full stay in the top level because they are shared across lanes.

Test Plan (WIDTH=4, DEPTH=3, RST_VAL=4'b0101):
1. Reset, then release with en=0, load=0 for 3 cycles → q0=0101, tap=0000, or_out=0101 from the first post-reset clock, full=0.
2. en=1 for 3 cycles from reset state → q0 sequence 1010, 0101, 1010; tap=0000, 0101 (cycle 2), 1010 (cycle 3); full=1 after the 2nd en cycle.
3. After full=1, load=1, en=0, load_val=1100 → q0=1100, tap unchanged, full=0 next cycle; 2 more en cycles → full=1.
4. Simultaneous load=1, en=1, load_val=0011 with q0=1010 → q0=0011, stage1=1010, fill=0; the next cycle or_out=1011.
5. Assert rst_n=0 asynchronously mid-cycle while en=1 and full=1 → all outputs reach reset values before the next clk edge; counting restarts from 0.
6. With TOGGLE_SHIFT_PIPE_CHG_DET_EN: en pulse on q0=0101 → chg=1111 for exactly 1 cycle; load of 0101 onto 0101 → chg=0000.

Source files
------------

// File: rtl/toggle_shift_pkg.sv
// Shared types and helpers for the toggle/shift pipeline (toggle_shift_pipe).
// Stage-0 operation selects and the fill-counter width live here.
package toggle_shift_pkg;

  typedef enum logic [1:0] {
    TSP_HOLD   = 2'd0,
    TSP_TOGGLE = 2'd1,
    TSP_LOAD   = 2'd2
  } tsp_op_e;

  function automatic int fill_w(input int depth);
    return $clog2(depth);
  endfunction

  // load dominates en; the chain still shifts whenever en is high
  function automatic tsp_op_e tsp_op(input logic en, input logic load);
    if (load) begin
      return TSP_LOAD;
    end else if (en) begin
      return TSP_TOGGLE;
    end
    return TSP_HOLD;
  endfunction

endpackage

// File: rtl/toggle_shift_lane.sv
// One single-bit channel: stage-0 toggle/load flop, shift chain and OR register.
// Optional change-detect output when TOGGLE_SHIFT_PIPE_CHG_DET_EN is defined.
module toggle_shift_lane
  import toggle_shift_pkg::*;
#(
  parameter int   DEPTH   = 3,
  parameter logic RST_BIT = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  tsp_op_e op,
  input  logic    load_val,
  output logic    q0,
  output logic    tap,
  output logic    or_out
`ifdef TOGGLE_SHIFT_PIPE_CHG_DET_EN
  ,
  output logic    chg
`endif
);

  logic [DEPTH-1:0] stage_q, stage_d;
  logic             or_q, or_d;

  always_comb begin
    stage_d = stage_q;
    case (op)
      TSP_LOAD:   stage_d[0] = load_val;
      TSP_TOGGLE: stage_d[0] = ~stage_q[0];
      default:    stage_d[0] = stage_q[0];
    endcase
    if (en) begin
      stage_d[DEPTH-1:1] = stage_q[DEPTH-2:0];
    end
  end

  // The OR samples every clock so it trails any stage change by exactly one cycle
  always_comb begin
    or_d = stage_q[0] | stage_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {{(DEPTH-1){1'b0}}, RST_BIT};
      or_q    <= 1'b0;
    end else begin
      stage_q <= stage_d;
      or_q    <= or_d;
    end
  end

`ifdef TOGGLE_SHIFT_PIPE_CHG_DET_EN
  logic chg_q, chg_d;

  always_comb begin
    chg_d = stage_d[0] ^ stage_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;
`endif

  assign q0     = stage_q[0];
  assign tap    = stage_q[DEPTH-1];
  assign or_out = or_q;

endmodule

// File: rtl/toggle_shift_pipe.sv
// Multi-channel toggle/shift pipeline with registered OR and saturating fill counter.
// Define TOGGLE_SHIFT_PIPE_CHG_DET_EN to add the registered per-channel chg output.
module toggle_shift_pipe
  import toggle_shift_pkg::*;
#(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] or_out,
  output logic             full
`ifdef TOGGLE_SHIFT_PIPE_CHG_DET_EN
  ,
  output logic [WIDTH-1:0] chg
`endif
);

  localparam int            FW       = fill_w(DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH - 1);

  tsp_op_e       op;
  logic [FW-1:0] fill_q, fill_d;

  assign op = tsp_op(en, load);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    toggle_shift_lane #(
      .DEPTH   (DEPTH),
      .RST_BIT (RST_VAL[i])
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .op       (op),
      .load_val (load_val[i]),
      .q0       (q0[i]),
      .tap      (tap[i]),
      .or_out   (or_out[i])
`ifdef TOGGLE_SHIFT_PIPE_CHG_DET_EN
      ,
      .chg      (chg[i])
`endif
    );
  end

  // Counts shifts since the last load, saturating once the chain is fully refilled
  always_comb begin
    fill_d = fill_q;
    case (op)
      TSP_LOAD:   fill_d = '0;
      TSP_TOGGLE: if (fill_q < FILL_MAX) fill_d = fill_q + 1'b1;
      default:    fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign full = (fill_q == FILL_MAX);

endmodule
